pa_fdsu_wb_buf: RTL and testbench
=================================

Name: pa_fdsu_wb_buf

Overview:
Writeback buffer directly downstream of the FDSU pack stage. It captures packed single-precision results (data, fflags, destination freg) and queues them in a small FIFO. It presents them to the FP register-file write port with a valid/ready handshake and accumulates the sticky fflags committed to fcsr. It also gives the issue logic a pending-destination check for RAW hazards against queued results.

Parameters:
DEPTH, 2, number of FIFO entries; power of two, >= 2
PTR_W, $clog2(DEPTH), index width; derived, not overridden

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
pack_vld_i  input  1  pack stage presents a result
pack_rdy_o  output  1  buffer can accept (= !full; no combinational path from wb_rdy_i)
pack_data_i  input  32  packed result
pack_fflags_i  input  5  {NV,DZ,OF,UF,NX} from pack stage
pack_freg_i  input  5  destination freg
wb_vld_o  output  1  head entry valid
wb_rdy_i  input  1  regfile port accepts
wb_data_o  output  32  head data
wb_freg_o  output  5  head freg
wb_fflags_o  output  5  head fflags
flush_i  input  1  pipeline flush; discard all queued entries
fflags_clr_i  input  1  clear accumulated fflags (fcsr write)
fflags_acc_o  output  5  sticky OR of committed fflags
chk_freg_i  input  5  freg to test for a pending write
chk_hit_o  output  1  some valid queued entry targets chk_freg_i
cnt_o  output  PTR_W+1  current occupancy
busy_o  output  1  cnt_o != 0

Behaviour:
- Reset (rst_i=1 at posedge): wr/rd pointers=0, cnt_o=0, all entry valid bits=0, fflags_acc_o=0, wb_vld_o=0, wb_data_o/wb_freg_o/wb_fflags_o=0, pack_rdy_o=1 in the following cycle. Reset mid-transfer drops every entry without accumulating flags.
- Enqueue: pack_vld_i && pack_rdy_o at posedge; entry written at wr_ptr; wr_ptr++.
- Dequeue: wb_vld_o && wb_rdy_i at posedge; rd_ptr++.
- Latency: a result enqueued into an empty buffer appears on wb_* in the next cycle (registered head).
- Pointers are PTR_W+1 bits and wrap naturally. full = MSBs differ && low bits equal. empty = pointers equal.
- Full with simultaneous dequeue: pack_rdy_o stays 0 that cycle (no pass-through). Empty: wb_vld_o=0, and wb_* hold the last value or 0 after reset.
- Simultaneous enqueue+dequeue when not full/empty: cnt unchanged, both pointers advance.
- wb_* hold stable while wb_vld_o && !wb_rdy_i.
- Accumulator: on each dequeue, acc |= head fflags. fflags_clr_i and dequeue in the same cycle gives acc = head fflags (clear first, then OR). fflags_clr_i alone gives acc=0.
- flush_i: next cycle cnt=0, pointers=0, wb_vld_o=0. Flush wins over same-cycle enqueue and dequeue. Flushed entries never reach acc, including a head accepted by wb_rdy_i that cycle. flush_i and fflags_clr_i together: acc=0.
- chk_hit_o: combinational OR over valid entries of (freg == chk_freg_i). freg 0 compares like any other (FP f0 is writable). Entries dequeuing in the current cycle still count as hits.
- No X on outputs at any time after reset.

Optional Feature:
FDSU_WB_BYPASS_EN
- Defined: when the buffer is empty, not flushing, and pack_vld_i=1, wb_vld_o/wb_* are driven combinationally from pack_*. If wb_rdy_i=1 the result retires the same cycle without being written (acc updated as a dequeue, cnt unchanged). Otherwise it is enqueued normally. chk_hit_o also matches pack_freg_i in that case.
- Undefined: strict 1-cycle latency as above; no combinational path from pack_* to wb_*.

Decomposition:
- Shared package pa_fpu_pkg: typedef fflags_t (5-bit packed struct nv,dz,of,uf,nx); typedef fdsu_wb_entry_t {data[31:0], fflags_t, freg[4:0]}; constant FREG_W=5.
- One natural sub-module: pa_fdsu_wb_fifo (generic DEPTH FIFO of fdsu_wb_entry_t with per-entry valid vector exported for the hazard compare). Accumulator, flush and hazard logic stay in the top.

Test Plan:
- Reset, then enqueue data=0x3F800000, fflags=5'b00001, freg=3 with wb_rdy_i=1 -> wb_vld_o=1 one cycle later with those values; after dequeue, fflags_acc_o=5'b00001, cnt_o=0.
- Hold wb_rdy_i=0, enqueue 3 results (DEPTH=2) -> pack_rdy_o=0 after the 2nd; the 3rd is held upstream; cnt_o=2. Raise wb_rdy_i -> FIFO order preserved, and pack_rdy_o=1 the cycle after the first dequeue.
- Queue freg=7 and freg=12, chk_freg_i=12 -> chk_hit_o=1. chk_freg_i=5 -> 0. After both dequeue, chk_freg_i=12 -> 0.
- Commit fflags 5'b00100 then 5'b00011 -> acc=5'b00111. Assert fflags_clr_i with dequeue of 5'b10000 -> acc=5'b10000.
- Two entries queued with fflags 5'b11111, flush_i with wb_rdy_i=1 and pack_vld_i=1 -> next cycle cnt_o=0, wb_vld_o=0, acc unchanged, incoming result dropped.
- FDSU_WB_BYPASS_EN defined, empty buffer, pack_vld_i=1, wb_rdy_i=1 -> wb_vld_o=1 the same cycle with pack data, cnt_o stays 0. Without the macro -> wb_vld_o=1 one cycle later.

Source files
------------

// File: rtl/pa_fpu_pkg.sv
// rtl/pa_fpu_pkg.sv - shared FPU types for the FDSU writeback path
package pa_fpu_pkg;

    localparam int FREG_W = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic [31:0]       data;
        fflags_t           fflags;
        logic [FREG_W-1:0] freg;
    } fdsu_wb_entry_t;

endpackage

// File: rtl/pa_fdsu_wb_fifo.sv
// rtl/pa_fdsu_wb_fifo.sv - DEPTH-entry FIFO of writeback entries with per-entry valid/freg export
module pa_fdsu_wb_fifo
    import pa_fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic                           wr_en_i,
    input  fdsu_wb_entry_t                 wr_entry_i,
    input  logic                           rd_en_i,
    output fdsu_wb_entry_t                 head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [PTR_W:0]                 cnt_o,
    output logic [DEPTH-1:0]               ent_vld_o,
    output logic [DEPTH-1:0][FREG_W-1:0]   ent_freg_o
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    fdsu_wb_entry_t   mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             do_wr, do_rd;

    assign wr_idx  = wr_ptr_q[PTR_W-1:0];
    assign rd_idx  = rd_ptr_q[PTR_W-1:0];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_idx];
    assign do_wr   = wr_en_i && !full_o && !clr_i;
    assign do_rd   = rd_en_i && !empty_o && !clr_i;
    assign ent_vld_o = vld_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_freg_o[i] = mem_q[i].freg;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            vld_d    = '0;
        end else begin
            if (do_rd) begin
                rd_ptr_d      = rd_ptr_q + PTR_ONE;
                vld_d[rd_idx] = 1'b0;
            end
            if (do_wr) begin
                wr_ptr_d      = wr_ptr_q + PTR_ONE;
                vld_d[wr_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            if (do_wr) begin
                mem_q[wr_idx] <= wr_entry_i;
            end
        end
    end

endmodule

// File: rtl/pa_fdsu_wb_buf.sv
// rtl/pa_fdsu_wb_buf.sv - FDSU writeback buffer: result FIFO, sticky fflags, RAW pending check
// Optional same-cycle bypass when empty: FDSU_WB_BYPASS_EN
module pa_fdsu_wb_buf
    import pa_fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pack_vld_i,
    output logic              pack_rdy_o,
    input  logic [31:0]       pack_data_i,
    input  logic [4:0]        pack_fflags_i,
    input  logic [4:0]        pack_freg_i,
    output logic              wb_vld_o,
    input  logic              wb_rdy_i,
    output logic [31:0]       wb_data_o,
    output logic [4:0]        wb_freg_o,
    output logic [4:0]        wb_fflags_o,
    input  logic              flush_i,
    input  logic              fflags_clr_i,
    output logic [4:0]        fflags_acc_o,
    input  logic [4:0]        chk_freg_i,
    output logic              chk_hit_o,
    output logic [PTR_W:0]    cnt_o,
    output logic              busy_o
);

    fdsu_wb_entry_t                 pack_ent, head_ent, out_ent;
    fdsu_wb_entry_t                 last_q, last_d;
    fflags_t                        acc_q, acc_d;
    logic                           fifo_full, fifo_empty;
    logic                           fifo_wr, fifo_rd;
    logic                           byp, retire;
    logic [DEPTH-1:0]               ent_vld;
    logic [DEPTH-1:0][FREG_W-1:0]   ent_freg;

    assign pack_ent = {pack_data_i, pack_fflags_i, pack_freg_i};

`ifdef FDSU_WB_BYPASS_EN
    assign byp = fifo_empty && !flush_i && pack_vld_i;
`else
    assign byp = 1'b0;
`endif

    pa_fdsu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (flush_i),
        .wr_en_i    (fifo_wr),
        .wr_entry_i (pack_ent),
        .rd_en_i    (fifo_rd),
        .head_o     (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (cnt_o),
        .ent_vld_o  (ent_vld),
        .ent_freg_o (ent_freg)
    );

    // When empty the port shows the last retired entry (zero after reset) rather than a stale slot.
    always_comb begin
        out_ent = last_q;
        if (!fifo_empty) begin
            out_ent = head_ent;
        end else if (byp) begin
            out_ent = pack_ent;
        end
        wb_vld_o = !fifo_empty || byp;
        retire   = wb_vld_o && wb_rdy_i && !flush_i;
        fifo_rd  = retire && !fifo_empty;
        fifo_wr  = pack_vld_i && !fifo_full && !flush_i && !(byp && wb_rdy_i);
        last_d   = retire ? out_ent : last_q;
        acc_d    = fflags_clr_i ? fflags_t'('0) : acc_q;
        if (retire) begin
            acc_d = fflags_t'(acc_d | out_ent.fflags);
        end
    end

    always_comb begin
        chk_hit_o = byp && (pack_freg_i == chk_freg_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_freg[i] == chk_freg_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            last_q <= '0;
        end else begin
            acc_q  <= acc_d;
            last_q <= last_d;
        end
    end

    assign pack_rdy_o   = !fifo_full;
    assign wb_data_o    = out_ent.data;
    assign wb_freg_o    = out_ent.freg;
    assign wb_fflags_o  = out_ent.fflags;
    assign fflags_acc_o = acc_q;
    assign busy_o       = (cnt_o != '0);

endmodule

// File: tb/tb_pa_fdsu_wb_buf.sv
// tb/tb_pa_fdsu_wb_buf.sv - scoreboard bench for pa_fdsu_wb_buf (DEPTH=2)
module tb_pa_fdsu_wb_buf;
    import pa_fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        pack_vld_i = 1'b0;
    logic        pack_rdy_o;
    logic [31:0] pack_data_i = '0;
    logic [4:0]  pack_fflags_i = '0;
    logic [4:0]  pack_freg_i = '0;
    logic        wb_vld_o;
    logic        wb_rdy_i = 1'b0;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_freg_o;
    logic [4:0]  wb_fflags_o;
    logic        flush_i = 1'b0;
    logic        fflags_clr_i = 1'b0;
    logic [4:0]  fflags_acc_o;
    logic [4:0]  chk_freg_i = '0;
    logic        chk_hit_o;
    logic [1:0]  cnt_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    fdsu_wb_entry_t sb[$];

    always #5 clk = ~clk;

    pa_fdsu_wb_buf #(.DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pack_vld_i   (pack_vld_i),
        .pack_rdy_o   (pack_rdy_o),
        .pack_data_i  (pack_data_i),
        .pack_fflags_i(pack_fflags_i),
        .pack_freg_i  (pack_freg_i),
        .wb_vld_o     (wb_vld_o),
        .wb_rdy_i     (wb_rdy_i),
        .wb_data_o    (wb_data_o),
        .wb_freg_o    (wb_freg_o),
        .wb_fflags_o  (wb_fflags_o),
        .flush_i      (flush_i),
        .fflags_clr_i (fflags_clr_i),
        .fflags_acc_o (fflags_acc_o),
        .chk_freg_i   (chk_freg_i),
        .chk_hit_o    (chk_hit_o),
        .cnt_o        (cnt_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] ff, input logic [4:0] fr, input bit expect_out);
        pack_vld_i    = 1'b1;
        pack_data_i   = d;
        pack_fflags_i = ff;
        pack_freg_i   = fr;
        if (expect_out) sb.push_back({d, ff, fr});
    endtask

    // Monitor: every accepted writeback must match the oldest expected entry.
    initial begin
        fdsu_wb_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && wb_vld_o && wb_rdy_i && !flush_i) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_data", 64'(wb_data_o), 64'(e.data));
                    check("wb_fflags", 64'(wb_fflags_o), 64'(e.fflags));
                    check("wb_freg", 64'(wb_freg_o), 64'(e.freg));
                end
            end
        end
    end

    initial begin
        step();
        step();
        rst_i = 1'b0;
        check("rst_cnt", 64'(cnt_o), 64'd0);
        check("rst_wb_vld", 64'(wb_vld_o), 64'd0);
        check("rst_wb_data", 64'(wb_data_o), 64'd0);
        check("rst_acc", 64'(fflags_acc_o), 64'd0);
        check("rst_pack_rdy", 64'(pack_rdy_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);

        // Single result into empty buffer.
        wb_rdy_i = 1'b1;
        drive(32'h3F800000, 5'b00001, 5'd3, 1'b1);
        #1;
`ifdef FDSU_WB_BYPASS_EN
        check("byp_same_cycle_vld", 64'(wb_vld_o), 64'd1);
        step();
        pack_vld_i = 1'b0;
`else
        check("no_comb_path_vld", 64'(wb_vld_o), 64'd0);
        step();
        pack_vld_i = 1'b0;
        check("lat1_vld", 64'(wb_vld_o), 64'd1);
        check("lat1_cnt", 64'(cnt_o), 64'd1);
        step();
`endif
        check("t1_acc", 64'(fflags_acc_o), 64'h01);
        check("t1_cnt", 64'(cnt_o), 64'd0);
        check("t1_vld", 64'(wb_vld_o), 64'd0);

        // Fill to full with writeback stalled, third result held upstream.
        wb_rdy_i = 1'b0;
        drive(32'h40000000, 5'b00100, 5'd7, 1'b1);
        step();
        check("fill1_cnt", 64'(cnt_o), 64'd1);
        check("fill1_rdy", 64'(pack_rdy_o), 64'd1);
        drive(32'h40400000, 5'b00011, 5'd12, 1'b1);
        step();
        check("full_cnt", 64'(cnt_o), 64'd2);
        check("full_rdy", 64'(pack_rdy_o), 64'd0);
        chk_freg_i = 5'd12;
        #1 check("hit_12", 64'(chk_hit_o), 64'd1);
        chk_freg_i = 5'd5;
        #1 check("miss_5", 64'(chk_hit_o), 64'd0);
        chk_freg_i = 5'd7;
        #1 check("hit_7", 64'(chk_hit_o), 64'd1);
        drive(32'h40800000, 5'b10000, 5'd9, 1'b1);
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        check("held_cnt", 64'(cnt_o), 64'd2);
        check("held_rdy", 64'(pack_rdy_o), 64'd0);
        check("clr_acc", 64'(fflags_acc_o), 64'd0);
        wb_rdy_i = 1'b1;
        step();
        check("deq1_rdy", 64'(pack_rdy_o), 64'd1);
        check("deq1_cnt", 64'(cnt_o), 64'd1);
        check("deq1_acc", 64'(fflags_acc_o), 64'h04);
        step();
        pack_vld_i = 1'b0;
        check("deq2_cnt", 64'(cnt_o), 64'd1);
        check("deq2_acc", 64'(fflags_acc_o), 64'h07);
        chk_freg_i = 5'd12;
        #1 check("gone_12", 64'(chk_hit_o), 64'd0);
        chk_freg_i = 5'd9;
        #1 check("hit_9", 64'(chk_hit_o), 64'd1);
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        check("clr_deq_acc", 64'(fflags_acc_o), 64'h10);
        check("clr_deq_cnt", 64'(cnt_o), 64'd0);

        // Flush beats same-cycle dequeue and enqueue.
        wb_rdy_i = 1'b0;
        drive(32'h11111111, 5'b11111, 5'd1, 1'b0);
        step();
        drive(32'h22222222, 5'b11111, 5'd2, 1'b0);
        step();
        check("pre_flush_cnt", 64'(cnt_o), 64'd2);
        drive(32'h33333333, 5'b11111, 5'd4, 1'b0);
        flush_i  = 1'b1;
        wb_rdy_i = 1'b1;
        step();
        flush_i    = 1'b0;
        pack_vld_i = 1'b0;
        check("flush_cnt", 64'(cnt_o), 64'd0);
        check("flush_vld", 64'(wb_vld_o), 64'd0);
        check("flush_acc", 64'(fflags_acc_o), 64'h10);
        check("flush_busy", 64'(busy_o), 64'd0);
        chk_freg_i = 5'd1;
        #1 check("flush_nohit", 64'(chk_hit_o), 64'd0);
        step();
        check("flush_drop_cnt", 64'(cnt_o), 64'd0);

        // freg 0 is a real target; dequeuing entry still hits.
        wb_rdy_i = 1'b0;
        drive(32'h3F000000, 5'b01000, 5'd0, 1'b1);
        step();
        pack_vld_i = 1'b0;
        chk_freg_i = 5'd0;
        #1 check("hit_f0", 64'(chk_hit_o), 64'd1);
        wb_rdy_i = 1'b1;
        #1 check("hit_f0_deq", 64'(chk_hit_o), 64'd1);
        step();
        check("f0_acc", 64'(fflags_acc_o), 64'h18);
        check("f0_nohit", 64'(chk_hit_o), 64'd0);
        flush_i      = 1'b1;
        fflags_clr_i = 1'b1;
        step();
        flush_i      = 1'b0;
        fflags_clr_i = 1'b0;
        check("flush_clr_acc", 64'(fflags_acc_o), 64'd0);

        // Reset mid-transfer drops entries without touching acc.
        wb_rdy_i = 1'b0;
        drive(32'hAAAA5555, 5'b00010, 5'd20, 1'b0);
        step();
        drive(32'h5555AAAA, 5'b00010, 5'd21, 1'b0);
        step();
        pack_vld_i = 1'b0;
        check("pre_rst_cnt", 64'(cnt_o), 64'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mid_rst_cnt", 64'(cnt_o), 64'd0);
        check("mid_rst_vld", 64'(wb_vld_o), 64'd0);
        check("mid_rst_acc", 64'(fflags_acc_o), 64'd0);
        check("mid_rst_data", 64'(wb_data_o), 64'd0);
        check("mid_rst_rdy", 64'(pack_rdy_o), 64'd1);
        step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
